// File: rtl/draw_card_grid_if.sv
// VGA bus between pipeline stages: timing counters, sync and blank strobes, 12-bit rgb.
interface draw_card_grid_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport master (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport slave  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_card_grid.sv
// Card-grid renderer on the VGA bus, 2-cycle latency, with one-at-a-time flip animation.
// Define DRAW_CARD_GRID_BORDER_EN to draw a 2-px cursor border around card cursor_idx.
module draw_card_grid #(
  parameter int unsigned X_POS        = 64,
  parameter int unsigned Y_POS        = 48,
  parameter int unsigned CARD_W       = 96,
  parameter int unsigned CARD_H       = 128,
  parameter int unsigned GAP          = 16,
  parameter int unsigned COLS         = 4,
  parameter int unsigned ROWS         = 4,
  parameter int unsigned ANIM_FRAMES  = 8,
  parameter int unsigned STEP_PX      = 6,
  parameter logic [11:0] BACK_COLOR   = 12'h00F,
  parameter logic [11:0] MATCH_COLOR  = 12'h222,
`ifdef DRAW_CARD_GRID_BORDER_EN
  parameter logic [11:0] BORDER_COLOR = 12'hFF0,
`endif
  localparam int unsigned N     = ROWS * COLS,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic                 pclk,
  input  logic                 rst,
  input  logic                 en,
  draw_card_grid_if.slave      vga_in,
  draw_card_grid_if.master     vga_out,
  input  logic [12*N-1:0]      face_colors,
  input  logic [N-1:0]         card_revealed,
  input  logic [N-1:0]         card_matched,
  input  logic                 flip_req,
  input  logic [IDX_W-1:0]     flip_idx,
  input  logic                 flip_to,
  output logic                 busy,
  output logic                 flip_done,
  input  logic [IDX_W-1:0]     cursor_idx
);

  localparam int unsigned K_W = $clog2(ANIM_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, SHRINK, EXPAND} state_t;

  function automatic logic [10:0] cell_x0(input int unsigned c);
    return 11'(X_POS + c * (CARD_W + GAP));
  endfunction

  function automatic logic [10:0] cell_y0(input int unsigned r);
    return 11'(Y_POS + r * (CARD_H + GAP));
  endfunction

  state_t           state;
  logic [K_W-1:0]   k;
  logic [IDX_W-1:0] anim_idx;
  logic             anim_to;
  logic             vblnk_prev;
  logic             frame_tick;
  logic             idx_ok;

  logic        col_hit, row_hit;
  logic [10:0] col_n, row_n, xoff, yoff;
  logic [11:0] face_arr [N];

  logic             s1_en, s1_hit;
  logic [IDX_W-1:0] s1_idx;
  logic [10:0]      s1_xoff;
  logic [10:0]      s1_h, s1_v;
  logic             s1_hs, s1_vs, s1_hb, s1_vb;
  logic [11:0]      s1_rgb;
`ifdef DRAW_CARD_GRID_BORDER_EN
  logic [10:0]      s1_yoff;
`endif

  logic [10:0] inset;
  logic        in_band, anim_here, shown;
  logic [11:0] rgb_nxt;

  // A full power-of-two grid makes every representable index valid.
  if (N == (1 << IDX_W)) begin : g_idx_full
    assign idx_ok = 1'b1;
  end else begin : g_idx_part
    assign idx_ok = (32'(flip_idx) < N);
  end

  always_comb begin
    for (int unsigned i = 0; i < N; i++) face_arr[i] = face_colors[12*i +: 12];
  end

  // Column / row decode of the incoming pixel.
  always_comb begin
    col_hit = 1'b0;
    col_n   = '0;
    xoff    = '0;
    row_hit = 1'b0;
    row_n   = '0;
    yoff    = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      if (vga_in.hcount >= cell_x0(c) && vga_in.hcount < cell_x0(c) + 11'(CARD_W)) begin
        col_hit = 1'b1;
        col_n   = 11'(c);
        xoff    = vga_in.hcount - cell_x0(c);
      end
    end
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (vga_in.vcount >= cell_y0(r) && vga_in.vcount < cell_y0(r) + 11'(CARD_H)) begin
        row_hit = 1'b1;
        row_n   = 11'(r);
        yoff    = vga_in.vcount - cell_y0(r);
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      s1_en   <= 1'b0;
      s1_hit  <= 1'b0;
      s1_idx  <= '0;
      s1_xoff <= '0;
      s1_h    <= '0;
      s1_v    <= '0;
      s1_hs   <= 1'b0;
      s1_vs   <= 1'b0;
      s1_hb   <= 1'b0;
      s1_vb   <= 1'b0;
      s1_rgb  <= '0;
`ifdef DRAW_CARD_GRID_BORDER_EN
      s1_yoff <= '0;
`endif
    end else begin
      s1_en   <= en;
      s1_hit  <= col_hit & row_hit;
      s1_idx  <= IDX_W'(row_n * 11'(COLS) + col_n);
      s1_xoff <= xoff;
      s1_h    <= vga_in.hcount;
      s1_v    <= vga_in.vcount;
      s1_hs   <= vga_in.hsync;
      s1_vs   <= vga_in.vsync;
      s1_hb   <= vga_in.hblnk;
      s1_vb   <= vga_in.vblnk;
      s1_rgb  <= vga_in.rgb;
`ifdef DRAW_CARD_GRID_BORDER_EN
      s1_yoff <= yoff;
`endif
    end
  end

  // Pixel colour: matched, then animation band, then revealed/back; border on top.
  always_comb begin
    inset     = 11'(k) * 11'(STEP_PX);
    in_band   = (s1_xoff >= inset) && (s1_xoff < 11'(CARD_W) - inset);
    anim_here = (state != IDLE) && (s1_idx == anim_idx);
    shown     = (state == SHRINK) ? ~anim_to : anim_to;
    rgb_nxt   = s1_rgb;
    if (s1_en && s1_hit) begin
      if (card_matched[s1_idx])       rgb_nxt = MATCH_COLOR;
      else if (anim_here) begin
        if (in_band)                  rgb_nxt = shown ? face_arr[s1_idx] : BACK_COLOR;
      end
      else if (card_revealed[s1_idx]) rgb_nxt = face_arr[s1_idx];
      else                            rgb_nxt = BACK_COLOR;
`ifdef DRAW_CARD_GRID_BORDER_EN
      if (s1_idx == cursor_idx &&
          (s1_xoff < 11'd2 || s1_xoff >= 11'(CARD_W - 2) ||
           s1_yoff < 11'd2 || s1_yoff >= 11'(CARD_H - 2)))
        rgb_nxt = BORDER_COLOR;
`endif
    end
  end

`ifndef DRAW_CARD_GRID_BORDER_EN
  logic unused_c;
  assign unused_c = ^{cursor_idx, yoff};
`endif

  always_ff @(posedge pclk) begin
    if (rst) begin
      vga_out.hcount <= '0;
      vga_out.vcount <= '0;
      vga_out.hsync  <= 1'b0;
      vga_out.vsync  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.rgb    <= '0;
    end else begin
      vga_out.hcount <= s1_h;
      vga_out.vcount <= s1_v;
      vga_out.hsync  <= s1_hs;
      vga_out.vsync  <= s1_vs;
      vga_out.hblnk  <= s1_hb;
      vga_out.vblnk  <= s1_vb;
      vga_out.rgb    <= rgb_nxt;
    end
  end

  // Frame strobe on vblnk rising edge, then flip FSM stepping once per frame.
  always_ff @(posedge pclk) begin
    if (rst) begin
      vblnk_prev <= 1'b0;
      frame_tick <= 1'b0;
      state      <= IDLE;
      k          <= '0;
      anim_idx   <= '0;
      anim_to    <= 1'b0;
      busy       <= 1'b0;
      flip_done  <= 1'b0;
    end else begin
      vblnk_prev <= vga_in.vblnk;
      frame_tick <= vga_in.vblnk & ~vblnk_prev;
      flip_done  <= 1'b0;
      case (state)
        IDLE: begin
          // A request coinciding with the done pulse belongs to the finished flip.
          if (flip_req && idx_ok && !flip_done) begin
            anim_idx <= flip_idx;
            anim_to  <= flip_to;
            k        <= '0;
            state    <= SHRINK;
            busy     <= 1'b1;
          end
        end
        SHRINK: begin
          if (frame_tick) begin
            k <= k + K_W'(1);
            if (k == K_W'(ANIM_FRAMES - 1)) state <= EXPAND;
          end
        end
        EXPAND: begin
          if (frame_tick) begin
            k <= k - K_W'(1);
            if (k == K_W'(1)) begin
              state     <= IDLE;
              busy      <= 1'b0;
              flip_done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_card_grid.sv
// Scoreboard bench for draw_card_grid: stimulus queues expected pixels, a monitor checks them.
module tb_draw_card_grid;
  logic pclk = 1'b0;
  logic rst  = 1'b1;
  logic en   = 1'b0;
  logic [12*16-1:0] face;
  logic [15:0] rev, mat;
  logic req, to, busy, done;
  logic [3:0] idx, cur;
  logic req2, busy2, done2;
  logic [3:0] idx2;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic got;

  typedef struct {
    int          due;
    logic [33:0] exp;
    string       nm;
  } ent_t;
  ent_t sb[$];
  ent_t mon_e;

  draw_card_grid_if vin();
  draw_card_grid_if vout();
  draw_card_grid_if vout2();

  draw_card_grid dut (
    .pclk(pclk), .rst(rst), .en(en), .vga_in(vin), .vga_out(vout),
    .face_colors(face), .card_revealed(rev), .card_matched(mat),
    .flip_req(req), .flip_idx(idx), .flip_to(to),
    .busy(busy), .flip_done(done), .cursor_idx(cur)
  );

  // 3x4 grid so that out-of-range indices are representable.
  draw_card_grid #(.ROWS(3)) dut2 (
    .pclk(pclk), .rst(rst), .en(en), .vga_in(vin), .vga_out(vout2),
    .face_colors(face[12*12-1:0]), .card_revealed(rev[11:0]), .card_matched(mat[11:0]),
    .flip_req(req2), .flip_idx(idx2), .flip_to(to),
    .busy(busy2), .flip_done(done2), .cursor_idx(cur)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge pclk);
    #1;
    cyc++;
    if (done) done_cnt++;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      chk(mon_e.nm, 64'({vout.hcount, vout.vcount, vout.rgb}), 64'(mon_e.exp));
    end
  end

  task automatic probe(input string nm, input int h, input int v,
                       input logic [11:0] rin, input logic [11:0] exp);
    ent_t t;
    @(negedge pclk);
    vin.hcount = 11'(h);
    vin.vcount = 11'(v);
    vin.rgb    = rin;
    t.due = cyc + 2;
    t.exp = {11'(h), 11'(v), exp};
    t.nm  = nm;
    sb.push_back(t);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge pclk);
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic tick();
    @(negedge pclk);
    vin.vblnk = 1'b1;
    repeat (3) @(negedge pclk);
    vin.vblnk = 1'b0;
    repeat (2) @(negedge pclk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1);
  end

  initial begin
    vin.hcount = 11'd5; vin.vcount = 11'd7; vin.rgb = 12'hABC;
    vin.hsync = 1'b1; vin.vsync = 1'b1; vin.hblnk = 1'b1; vin.vblnk = 1'b0;
    for (int i = 0; i < 16; i++) face[12*i +: 12] = 12'h555;
    face[11:0]  = 12'h0F0;
    face[71:60] = 12'hF00;
    rev = '0; mat = '0; req = 1'b0; idx = '0; to = 1'b0; cur = 4'd5;
    req2 = 1'b0; idx2 = '0;

    repeat (2) @(negedge pclk);
    chk("rst_vga", 64'({vout.hcount, vout.vcount, vout.hsync, vout.vsync,
                        vout.hblnk, vout.vblnk, vout.rgb}), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst = 1'b0; en = 1'b1;
    vin.hsync = 1'b0; vin.vsync = 1'b0; vin.hblnk = 1'b0;

    probe("card0_tl", 64, 48, 12'h0A5, 12'h00F);
    probe("gap_right", 160, 48, 12'h0A5, 12'h0A5);
    probe("left_out", 63, 48, 12'h0A6, 12'h0A6);
    probe("card0_br", 159, 175, 12'h0A7, 12'h00F);
    probe("gap_below", 64, 176, 12'h0A8, 12'h0A8);
    probe("card15_br", 495, 607, 12'h0A9, 12'h00F);
    probe("right_out", 496, 607, 12'h0AA, 12'h0AA);
    drain();

    rev[5] = 1'b1;
    probe("card5_face", 176, 192, 12'h333, 12'hF00);
    drain();
    mat[5] = 1'b1;
    probe("card5_match", 176, 192, 12'h333, 12'h222);
    drain();
    mat[5] = 1'b0;
    en = 1'b0;
    probe("en_off", 64, 48, 12'h444, 12'h444);
    drain();
    en = 1'b1;

    @(negedge pclk);
    chk("busy_pre_req", 64'(busy), 64'd0);
    req = 1'b1; idx = 4'd0; to = 1'b1; rev[0] = 1'b1;
    @(negedge pclk);
    req = 1'b0;
    chk("busy_after_req", 64'(busy), 64'd1);
    repeat (3) tick();
    probe("k3_left_edge", 64, 48, 12'h7E7, 12'h7E7);
    probe("k3_inset_last", 81, 48, 12'h7E7, 12'h7E7);
    probe("k3_band_first", 82, 48, 12'h7E7, 12'h00F);
    probe("k3_band_last", 141, 48, 12'h7E7, 12'h00F);
    probe("k3_right_inset", 142, 48, 12'h7E7, 12'h7E7);
    probe("k3_card1", 176, 48, 12'h7E7, 12'h00F);
    drain();

    @(negedge pclk);
    req = 1'b1; idx = 4'd1; to = 1'b1;
    @(negedge pclk);
    req = 1'b0;
    probe("busy_req_card1", 176, 48, 12'h7E7, 12'h00F);
    probe("busy_req_card0", 82, 48, 12'h7E7, 12'h00F);
    drain();

    repeat (5) tick();
    probe("k8_mid", 111, 48, 12'h7E8, 12'h7E8);
    probe("k8_left", 64, 48, 12'h7E8, 12'h7E8);
    drain();
    chk("busy_k8", 64'(busy), 64'd1);

    tick();
    probe("exp_k7_first", 106, 48, 12'h7E9, 12'h0F0);
    probe("exp_k7_inset", 105, 48, 12'h7E9, 12'h7E9);
    probe("exp_k7_last", 117, 48, 12'h7E9, 12'h0F0);
    probe("exp_k7_right", 153, 48, 12'h7E9, 12'h7E9);
    drain();

    repeat (6) tick();
    chk("busy_tick15", 64'(busy), 64'd1);
    chk("done_cnt_tick15", 64'(done_cnt), 64'd0);

    @(negedge pclk);
    vin.vblnk = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge pclk);
      if (done) got = 1'b1;
    end
    chk("done_seen", 64'(got), 64'd1);
    chk("busy_at_done", 64'(busy), 64'd0);
    req = 1'b1; idx = 4'd2; to = 1'b1;
    vin.vblnk = 1'b0;
    @(negedge pclk);
    req = 1'b0;
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("req_at_done_ignored", 64'(busy), 64'd0);
    @(negedge pclk);
    chk("still_idle", 64'(busy), 64'd0);
    probe("card0_face_tl", 64, 48, 12'h111, 12'h0F0);
    probe("card0_face_br", 159, 175, 12'h111, 12'h0F0);
    drain();
    chk("done_cnt_1", 64'(done_cnt), 64'd1);

    @(negedge pclk);
    req2 = 1'b1; idx2 = 4'd12;
    @(negedge pclk);
    idx2 = 4'd15;
    @(negedge pclk);
    req2 = 1'b0;
    chk("bad_idx_busy", 64'(busy2), 64'd0);
    @(negedge pclk);
    chk("bad_idx_done", 64'(done2), 64'd0);
    req2 = 1'b1; idx2 = 4'd11;
    @(negedge pclk);
    req2 = 1'b0;
    chk("good_idx_busy", 64'(busy2), 64'd1);

    @(negedge pclk);
    req = 1'b1; idx = 4'd3; to = 1'b1;
    @(negedge pclk);
    req = 1'b0;
    chk("busy_card3", 64'(busy), 64'd1);
    tick();
    tick();
    probe("card3_k2_inset", 400, 48, 12'h246, 12'h246);
    drain();
    @(negedge pclk);
    rst = 1'b1;
    @(negedge pclk);
    rst = 1'b0;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_done", 64'(done), 64'd0);
    repeat (20) tick();
    chk("rst_mid_no_done", 64'(done_cnt), 64'd1);
    chk("rst_mid_idle", 64'(busy), 64'd0);
    probe("card3_after_rst", 400, 48, 12'h246, 12'h00F);
    drain();

`ifdef DRAW_CARD_GRID_BORDER_EN
    cur = 4'd5;
    probe("border_outer", 176, 192, 12'h135, 12'hFF0);
    probe("border_inner", 177, 193, 12'h135, 12'hFF0);
    probe("border_clear", 178, 194, 12'h135, 12'hF00);
    drain();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
